// File: rtl/hsi_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : hsi_tx_sched
//  Description : HSI transmitter frame scheduler. Arbitrates four message
//                sources with starvation promotion, sequences the CRC
//                trailer, enforces an inter-frame gap and aborts stalled
//                frames with a watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module hsi_tx_sched #(
    parameter int GAP_TICKS     = 4,
    parameter int STARVE_LIM    = 3,
    parameter int TIMEOUT_TICKS = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en_i,
    input  logic [3:0] req_i,
    input  logic [3:0] req_en_i,
    input  logic [3:0] msg_end_i,
    input  logic       crc_end_i,
    output logic [3:0] grant_o,
    output logic       crc_tx_en_o,
    output logic [1:0] cur_src_o,
    output logic       busy_o,
    output logic       frame_abort_o,
    output logic [7:0] abort_cnt_o
);

    localparam logic [15:0] c_gap_lim    = 16'(GAP_TICKS);
    localparam logic [3:0]  c_starve_lim = 4'(STARVE_LIM);
    localparam logic [10:0] c_tmo_lim    = 11'(TIMEOUT_TICKS);
    localparam logic [10:0] c_tmo_last   = 11'(TIMEOUT_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_CRC  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  grant_q, grant_d;
    logic        crc_q, crc_d;
    logic [1:0]  cur_q, cur_d;
    logic        busy_q, busy_d;
    logic        abort_q, abort_d;
    logic [7:0]  abort_cnt_q, abort_cnt_d;
    logic [3:0]  starve_q [4];
    logic [3:0]  starve_d [4];
    logic [15:0] gap_q, gap_d;
    logic [10:0] wdog_q, wdog_d;

    logic [3:0]  w_req;
    logic [3:0]  w_starved;
    logic [3:0]  w_pick;
    logic [1:0]  w_win;
    logic        w_active;
    logic        w_timeout;
    logic        w_abort;

    // Starved requesters form their own priority tier above plain requests.
    always_comb begin
        w_req     = req_i & req_en_i;
        w_starved = '0;
        for (int i = 0; i < 4; i++) begin
            w_starved[i] = w_req[i] && (starve_q[i] == c_starve_lim);
        end
        w_pick = (w_starved != 4'd0) ? w_starved : w_req;
        w_win  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_pick[i]) begin
                w_win = 2'(i);
            end
        end
    end

    assign w_active  = (state_q == S_SEND) || (state_q == S_CRC);
    assign w_timeout = w_active && clk_en_i && (wdog_q == c_tmo_last);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        crc_d       = crc_q;
        cur_d       = cur_q;
        abort_d     = 1'b0;
        abort_cnt_d = abort_cnt_q;
        starve_d    = starve_q;
        gap_d       = gap_q;
        wdog_d      = wdog_q;
        w_abort     = 1'b0;

        // The timer parks at the limit, so a timeout overtaken by a normal
        // transition is consumed rather than re-armed.
        if (w_active && clk_en_i && (wdog_q != c_tmo_lim)) begin
            wdog_d = wdog_q + 11'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (w_req != 4'd0) begin
                    state_d = S_SEND;
                    grant_d = 4'b0001 << w_win;
                    cur_d   = w_win;
                    wdog_d  = '0;
                    for (int i = 0; i < 4; i++) begin
                        if (2'(i) == w_win) begin
                            starve_d[i] = '0;
                        end else if (w_req[i] && (starve_q[i] != c_starve_lim)) begin
                            starve_d[i] = starve_q[i] + 4'd1;
                        end
                    end
                end
            end
            S_SEND: begin
                if (msg_end_i[cur_q]) begin
                    state_d = S_CRC;
                    grant_d = '0;
                    crc_d   = 1'b1;
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                end
            end
            S_CRC: begin
                if (crc_end_i) begin
                    state_d = S_GAP;
                    crc_d   = 1'b0;
                    gap_d   = '0;
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == c_gap_lim) begin
                    state_d = S_IDLE;
                end else if (clk_en_i) begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_abort) begin
            state_d = S_GAP;
            grant_d = '0;
            crc_d   = 1'b0;
            gap_d   = '0;
            abort_d = 1'b1;
            if (abort_cnt_q != 8'hFF) begin
                abort_cnt_d = abort_cnt_q + 8'd1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            crc_q       <= 1'b0;
            cur_q       <= '0;
            busy_q      <= 1'b0;
            abort_q     <= 1'b0;
            abort_cnt_q <= '0;
            gap_q       <= '0;
            wdog_q      <= '0;
            for (int i = 0; i < 4; i++) begin
                starve_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            crc_q       <= crc_d;
            cur_q       <= cur_d;
            busy_q      <= busy_d;
            abort_q     <= abort_d;
            abort_cnt_q <= abort_cnt_d;
            gap_q       <= gap_d;
            wdog_q      <= wdog_d;
            for (int i = 0; i < 4; i++) begin
                starve_q[i] <= starve_d[i];
            end
        end
    end

    assign grant_o       = grant_q;
    assign crc_tx_en_o   = crc_q;
    assign cur_src_o     = cur_q;
    assign busy_o        = busy_q;
    assign frame_abort_o = abort_q;
    assign abort_cnt_o   = abort_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hsi_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hsi_tx_sched
//  Description : Self-checking bench for hsi_tx_sched: directed scenarios
//                plus randomized traffic against a frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hsi_tx_sched;

    localparam int GAP  = 4;
    localparam int LIM  = 3;
    localparam int TMO  = 1024;
    localparam int GAP2 = 0;
    localparam int LIM2 = 1;
    localparam int TMO2 = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en;
    logic [3:0] req, req_en, msg_end;
    logic       crc_end;

    logic [3:0] grant, grant2;
    logic       crc, crc2, busy, busy2, abort, abort2;
    logic [1:0] cur, cur2;
    logic [7:0] cnt, cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hsi_tx_sched #(.GAP_TICKS(GAP), .STARVE_LIM(LIM), .TIMEOUT_TICKS(TMO)) u_dut (
        .clk(clk), .rst(rst), .clk_en_i(clk_en), .req_i(req), .req_en_i(req_en),
        .msg_end_i(msg_end), .crc_end_i(crc_end), .grant_o(grant), .crc_tx_en_o(crc),
        .cur_src_o(cur), .busy_o(busy), .frame_abort_o(abort), .abort_cnt_o(cnt));

    hsi_tx_sched #(.GAP_TICKS(GAP2), .STARVE_LIM(LIM2), .TIMEOUT_TICKS(TMO2)) u_dut2 (
        .clk(clk), .rst(rst), .clk_en_i(clk_en), .req_i(req), .req_en_i(req_en),
        .msg_end_i(msg_end), .crc_end_i(crc_end), .grant_o(grant2), .crc_tx_en_o(crc2),
        .cur_src_o(cur2), .busy_o(busy2), .frame_abort_o(abort2), .abort_cnt_o(cnt2));

    // Frame-level reference model, one copy per instance.
    int         m_phase  [2];   // 0 idle, 1 message, 2 trailer, 3 gap
    int         m_starve [2][4];
    int         m_left   [2];   // watchdog ticks remaining in this frame
    int         m_gseen  [2];   // gap ticks seen so far
    logic [3:0] e_grant  [2];
    logic       e_crc    [2];
    logic [1:0] e_cur    [2];
    logic       e_abort  [2];
    logic [7:0] e_cnt    [2];

    task automatic model_step(input int k, input int gap_lim, input int s_lim, input int tmo,
                              input logic r_rst, input logic ce, input logic [3:0] r,
                              input logic [3:0] me, input logic ce_crc);
        int   w;
        logic expired;
        logic do_abort;
        do_abort   = 1'b0;
        e_abort[k] = 1'b0;
        if (r_rst) begin
            m_phase[k] = 0; e_grant[k] = 4'd0; e_crc[k] = 1'b0; e_cur[k] = 2'd0;
            e_cnt[k] = 8'd0; m_left[k] = 0; m_gseen[k] = 0;
            for (int i = 0; i < 4; i++) m_starve[k][i] = 0;
        end else if (m_phase[k] == 0) begin
            if (r != 4'd0) begin
                w = -1;
                for (int i = 0; i < 4; i++)
                    if (w < 0 && r[i] && m_starve[k][i] == s_lim) w = i;
                for (int i = 0; i < 4; i++)
                    if (w < 0 && r[i]) w = i;
                for (int i = 0; i < 4; i++) begin
                    if (i == w) m_starve[k][i] = 0;
                    else if (r[i]) m_starve[k][i] = (m_starve[k][i] + 1 > s_lim) ? s_lim : m_starve[k][i] + 1;
                end
                e_grant[k] = 4'(1 << w);
                e_cur[k]   = 2'(w);
                m_phase[k] = 1;
                m_left[k]  = tmo;
            end
        end else if (m_phase[k] == 1 || m_phase[k] == 2) begin
            expired = ce && (m_left[k] == 1);
            if (ce && m_left[k] > 0) m_left[k]--;
            if (m_phase[k] == 1 && me[e_cur[k]]) begin
                e_grant[k] = 4'd0; e_crc[k] = 1'b1; m_phase[k] = 2;
            end else if (m_phase[k] == 2 && ce_crc) begin
                e_crc[k] = 1'b0; m_phase[k] = 3; m_gseen[k] = 0;
            end else if (expired) begin
                do_abort = 1'b1;
            end
        end else begin
            if (m_gseen[k] == gap_lim) m_phase[k] = 0;
            else if (ce) m_gseen[k]++;
        end
        if (do_abort) begin
            e_abort[k] = 1'b1; e_grant[k] = 4'd0; e_crc[k] = 1'b0;
            m_phase[k] = 3; m_gseen[k] = 0;
            e_cnt[k] = (e_cnt[k] == 8'hFF) ? 8'hFF : e_cnt[k] + 8'd1;
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; req = 4'd0; req_en = 4'hF; msg_end = 4'd0; crc_end = 1'b0; clk_en = 1'b1;
        cyc; cyc;
        rst = 1'b0;
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        while (grant == 4'd0 && n < 40) begin
            cyc;
            n++;
        end
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while (busy && n < 40) begin
            cyc;
            n++;
        end
    endtask

    task automatic finish_frame(input int src);
        msg_end = 4'b0001 << src;
        cyc;
        msg_end = 4'd0;
        crc_end = 1'b1;
        cyc;
        crc_end = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 4'hF; req_en = 4'hF; msg_end = 4'hF; crc_end = 1'b1; clk_en = 1'b1;
        cyc; cyc;
        checks++;
        if (grant !== 4'd0 || crc !== 1'b0) begin
            errors++;
            $display("FAIL reset_grant: grant=%b crc=%b, expected 0000 0", grant, crc);
        end
        checks++;
        if (cur !== 2'd0 || busy !== 1'b0 || abort !== 1'b0 || cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_status: cur=%0d busy=%b abort=%b cnt=%0d, expected all 0", cur, busy, abort, cnt);
        end
        rst = 1'b0; req = 4'd0; msg_end = 4'd0; crc_end = 1'b0;
    endtask

    task automatic test_basic;
        int n;
        do_reset;
        req = 4'b0110;
        wait_grant(n);
        checks++;
        if (n !== 1 || grant !== 4'b0010 || cur !== 2'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_grant: lat=%0d grant=%b cur=%0d busy=%b, expected 1 0010 1 1", n, grant, cur, busy);
        end
        msg_end = 4'b0010; req = 4'b0100;
        cyc;
        msg_end = 4'd0;
        checks++;
        if (grant !== 4'd0 || crc !== 1'b1) begin
            errors++;
            $display("FAIL basic_crc: grant=%b crc=%b, expected 0000 1", grant, crc);
        end
        crc_end = 1'b1;
        cyc;
        crc_end = 1'b0;
        checks++;
        if (crc !== 1'b0 || busy !== 1'b1 || grant !== 4'd0) begin
            errors++;
            $display("FAIL basic_gap_entry: crc=%b busy=%b grant=%b, expected 0 1 0000", crc, busy, grant);
        end
        for (int i = 0; i < GAP; i++) begin
            cyc;
            checks++;
            if (busy !== 1'b1 || grant !== 4'd0) begin
                errors++;
                $display("FAIL basic_gap_hold%0d: busy=%b grant=%b, expected 1 0000", i, busy, grant);
            end
        end
        cyc;
        checks++;
        if (busy !== 1'b0 || grant !== 4'd0) begin
            errors++;
            $display("FAIL basic_idle: busy=%b grant=%b, expected 0 0000", busy, grant);
        end
        cyc;
        checks++;
        if (grant !== 4'b0100 || cur !== 2'd2) begin
            errors++;
            $display("FAIL basic_second: grant=%b cur=%0d, expected 0100 2", grant, cur);
        end
        req = 4'd0;
        finish_frame(2);
        wait_idle;
    endtask

    task automatic test_starvation;
        logic [3:0] exp_seq [8];
        logic [3:0] g;
        int         n;
        exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b1000};
        do_reset;
        req = 4'b1001;
        for (int f = 0; f < 8; f++) begin
            wait_grant(n);
            g = exp_seq[f];
            checks++;
            if (n >= 40 || grant !== g) begin
                errors++;
                $display("FAIL starve_frame%0d: grant=%b wait=%0d, expected %b", f, grant, n, g);
            end
            finish_frame(g[3] ? 3 : 0);
        end
        req = 4'd0;
        wait_idle;
    endtask

    task automatic test_mask;
        do_reset;
        req_en = 4'b1110; req = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            cyc;
            checks++;
            if (grant !== 4'd0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mask_cycle%0d: grant=%b busy=%b, expected 0000 0", i, grant, busy);
            end
        end
        req_en = 4'hF;
        cyc;
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL mask_release: grant=%b, expected 0001", grant);
        end
        req = 4'd0;
        finish_frame(0);
        wait_idle;
    endtask

    task automatic test_ignore_race;
        do_reset;
        req = 4'b0001;
        cyc;
        req = 4'd0;
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL race_grant: grant=%b, expected 0001", grant);
        end
        for (int k = 1; k < TMO; k++) begin
            if (k == 5) begin
                msg_end = 4'b0100; crc_end = 1'b1;
            end
            cyc;
            msg_end = 4'd0; crc_end = 1'b0;
            if (k == 5) begin
                checks++;
                if (grant !== 4'b0001 || crc !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL ignore_foreign: grant=%b crc=%b busy=%b, expected 0001 0 1", grant, crc, busy);
                end
            end
        end
        msg_end = 4'b0001;
        cyc;
        msg_end = 4'd0;
        checks++;
        if (crc !== 1'b1 || grant !== 4'd0 || abort !== 1'b0) begin
            errors++;
            $display("FAIL race_msg_end: crc=%b grant=%b abort=%b, expected 1 0000 0", crc, grant, abort);
        end
        for (int i = 0; i < 3; i++) begin
            cyc;
            checks++;
            if (abort !== 1'b0 || crc !== 1'b1 || cnt !== 8'd0) begin
                errors++;
                $display("FAIL race_crc_hold%0d: abort=%b crc=%b cnt=%0d, expected 0 1 0", i, abort, crc, cnt);
            end
        end
        crc_end = 1'b1;
        cyc;
        crc_end = 1'b0;
        wait_idle;
    endtask

    task automatic test_timeout;
        int bad;
        do_reset;
        req = 4'b0010;
        cyc;
        req = 4'd0;
        checks++;
        if (grant !== 4'b0010) begin
            errors++;
            $display("FAIL tmo_grant: grant=%b, expected 0010", grant);
        end
        bad = 0;
        for (int k = 1; k < TMO; k++) begin
            cyc;
            if (grant !== 4'b0010 || abort !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL tmo_early: %0d cycles lost grant or aborted, expected 0", bad);
        end
        cyc;
        checks++;
        if (abort !== 1'b1 || grant !== 4'd0 || crc !== 1'b0 || cnt !== 8'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL tmo_abort: abort=%b grant=%b crc=%b cnt=%0d busy=%b, expected 1 0000 0 1 1",
                     abort, grant, crc, cnt, busy);
        end
        for (int i = 0; i < GAP; i++) begin
            cyc;
            checks++;
            if (abort !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL tmo_gap%0d: abort=%b busy=%b, expected 0 1", i, abort, busy);
            end
        end
        cyc;
        checks++;
        if (busy !== 1'b0 || cnt !== 8'd1) begin
            errors++;
            $display("FAIL tmo_idle: busy=%b cnt=%0d, expected 0 1", busy, cnt);
        end
    endtask

    task automatic test_reset_mid_crc;
        int n;
        req = 4'b0100;
        wait_grant(n);
        msg_end = 4'b0100;
        cyc;
        msg_end = 4'd0;
        cyc;
        checks++;
        if (crc !== 1'b1 || cnt !== 8'd1) begin
            errors++;
            $display("FAIL rstcrc_pre: crc=%b cnt=%0d, expected 1 1", crc, cnt);
        end
        rst = 1'b1;
        cyc;
        rst = 1'b0;
        checks++;
        if (grant !== 4'd0 || crc !== 1'b0 || cur !== 2'd0 || busy !== 1'b0 || abort !== 1'b0 || cnt !== 8'd0) begin
            errors++;
            $display("FAIL rstcrc_values: grant=%b crc=%b cur=%0d busy=%b abort=%b cnt=%0d, expected all 0",
                     grant, crc, cur, busy, abort, cnt);
        end
        n = 0;
        while (grant == 4'd0 && n < 2) begin
            cyc;
            n++;
        end
        checks++;
        if (grant !== 4'b0100) begin
            errors++;
            $display("FAIL rstcrc_regrant: grant=%b after %0d clk, expected 0100", grant, n);
        end
        req = 4'd0;
        finish_frame(2);
        wait_idle;
    endtask

    task automatic test_random;
        logic [3:0] a_grant;
        logic       a_crc, a_busy, a_abort;
        logic [1:0] a_cur;
        logic [7:0] a_cnt;
        do_reset;
        model_step(0, GAP, LIM, TMO, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        model_step(1, GAP2, LIM2, TMO2, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        for (int c = 0; c < 4000; c++) begin
            rst    = ($urandom_range(0, 399) == 0);
            clk_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) req_en = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) msg_end[i] = ($urandom_range(0, 29) == 0);
            crc_end = ($urandom_range(0, 11) == 0);
            @(posedge clk);
            model_step(0, GAP, LIM, TMO, rst, clk_en, req & req_en, msg_end, crc_end);
            model_step(1, GAP2, LIM2, TMO2, rst, clk_en, req & req_en, msg_end, crc_end);
            #1;
            for (int k = 0; k < 2; k++) begin
                a_grant = (k == 0) ? grant : grant2;
                a_crc   = (k == 0) ? crc   : crc2;
                a_cur   = (k == 0) ? cur   : cur2;
                a_busy  = (k == 0) ? busy  : busy2;
                a_abort = (k == 0) ? abort : abort2;
                a_cnt   = (k == 0) ? cnt   : cnt2;
                checks++;
                if (a_grant !== e_grant[k] || a_crc !== e_crc[k] || a_cur !== e_cur[k] ||
                    a_busy !== (m_phase[k] != 0) || a_abort !== e_abort[k] || a_cnt !== e_cnt[k]) begin
                    errors++;
                    $display("FAIL random_dut%0d cyc%0d: grant=%b crc=%b cur=%0d busy=%b abort=%b cnt=%0d, expected %b %b %0d %b %b %0d",
                             k, c, a_grant, a_crc, a_cur, a_busy, a_abort, a_cnt,
                             e_grant[k], e_crc[k], e_cur[k], (m_phase[k] != 0), e_abort[k], e_cnt[k]);
                end
                checks++;
                if (!$onehot0(a_grant) || (a_grant != 4'd0 && a_crc)) begin
                    errors++;
                    $display("FAIL random_exclusive_dut%0d cyc%0d: grant=%b crc=%b, expected one-hot and exclusive", k, c, a_grant, a_crc);
                end
            end
        end
        rst = 1'b0; req = 4'd0; msg_end = 4'd0; crc_end = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_starvation;
        test_mask;
        test_ignore_race;
        test_timeout;
        test_reset_mid_crc;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hsi_tx_sched.md
Name: hsi_tx_sched

Overview:
Frame scheduler for the HSI master transmitter. It arbitrates four message sources (TM, BTC, SR, CCW) for the single shared coder. It grants one source per frame and sequences the CRC trailer after that source's last byte. It then enforces an inter-frame gap before the next arbitration. A per-frame watchdog aborts frames that stall and counts the aborts.

Parameters:
GAP_TICKS, 4, inter-frame gap length in clk_en ticks (0 = no gap)
STARVE_LIM, 3, consecutive lost arbitrations after which a requester is promoted (1..15)
TIMEOUT_TICKS, 1024, max clk_en ticks spent in SEND+CRC before abort (1..2047)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
clk_en  in  1  bit-rate tick; gap and watchdog count only on ticks
req  in  4  source requests; [0]=TM [1]=BTC [2]=SR [3]=CCW
req_en  in  4  per-source enable masks
msg_end  in  4  one-cycle pulse from each source on its last byte accepted
crc_end  in  1  one-cycle pulse from the CRC sender when the trailer is done
grant  out  4  one-hot grant; held for the whole message
crc_tx_en  out  1  CRC sender enable
cur_src  out  2  index of the current/last granted source
busy  out  1  high whenever state is not IDLE
frame_abort  out  1  one-cycle pulse on watchdog timeout
abort_cnt  out  8  saturating count of aborted frames

Behaviour:
- Reset (rst=1 at a clk edge, any state): state=IDLE; grant=0, crc_tx_en=0, cur_src=0, busy=0, frame_abort=0, abort_cnt=0; starvation counters=0; gap and watchdog timers=0.
- All outputs are registered.
- States: IDLE, SEND, CRC, GAP. Transitions are evaluated every clk, not gated by clk_en.
- Effective request: r = req & req_en.
- IDLE, r != 0, winner selection:
  - If any requester with r[i]=1 has starve_cnt[i]==STARVE_LIM, the winner is the lowest such index.
  - Otherwise the winner is the lowest index with r[i]=1 (TM highest priority).
- IDLE, on winning: next cycle grant[winner]=1, cur_src=winner, state=SEND. Latency is 1 clk from r to grant.
- Starvation counters update at the grant:
  - The winner's counter clears.
  - Every other i with r[i]=1 increments, saturating at STARVE_LIM.
  - Counters of non-requesting sources are unchanged.
- SEND:
  - Grant is held regardless of req changes.
  - Only msg_end[cur_src] is honoured; other msg_end bits and crc_end are ignored.
  - On msg_end[cur_src]: next cycle grant=0, crc_tx_en=1, state=CRC.
- CRC: crc_tx_en held high. On crc_end: next cycle crc_tx_en=0, state=GAP.
- GAP:
  - Gap counter clears on entry and increments per clk_en.
  - When it equals GAP_TICKS, state=IDLE.
  - If GAP_TICKS=0, GAP lasts exactly 1 clk.
  - Requests arriving during GAP wait; they are not lost while held high.
- Watchdog:
  - 11-bit timer clears on entry to SEND and increments on clk_en while in SEND or CRC.
  - When timer==TIMEOUT_TICKS: frame_abort=1 for one clk, grant=0, crc_tx_en=0, state=GAP, abort_cnt+1 (saturating at 255).
- Simultaneous events:
  - msg_end[cur_src] or crc_end in the same cycle as timeout: the normal transition wins and no abort is raised.
  - rst with any other input: reset wins.
- grant is always one-hot or zero. grant and crc_tx_en are never high together.

Test Plan:
- req=4'b0110, req_en=4'hF, idle → grant=4'b0010 one clk later; msg_end[1] → grant=0, crc_tx_en=1 next clk; crc_end → GAP of 4 clk_en ticks, then grant=4'b0100.
- req=4'b1001 held, TM re-requests every frame, STARVE_LIM=3 → CCW loses 3 arbitrations, then wins the 4th (grant=4'b1000); its counter returns to 0.
- req_en=4'b1110 with req=4'b0001 → no grant, busy stays 0.
- Grant BTC, never pulse msg_end, clk_en every clk, TIMEOUT_TICKS=1024 → frame_abort pulse at tick 1024, grant=0, abort_cnt=1, then GAP→IDLE.
- During SEND for source 0, pulse msg_end[2] and crc_end → ignored, grant stays 4'b0001. Then pulse msg_end[0] in the same clk as timeout → state=CRC, no abort.
- rst asserted mid-CRC → next clk all outputs at reset values. After rst release, the pending req is granted within 2 clk.
